hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Pipeline sequencing controller for the 5-stage RV32I core. Watches the ID, EX and MEM stages and drives the pipeline-register write enables, flushes and PC write enable. It resolves three conditions: load-use data hazards, taken branch/jump redirects and data-memory wait states, with a watchdog on memory waits. It sits beside the control decoder and gates its control bundle into ID/EX through `idex_flush`.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum consecutive MEM_WAIT cycles before `mem_err` is raised; legal range 1..65535.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction actually reads that source.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_MemRead`  in  1  the EX instruction is a load.
- `ex_redirect`  in  1  a branch resolved taken, or a jump, in EX.
- `mem_req`  in  1  the MEM-stage instruction is issuing MemRead or MemWrite.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC register load enable.
- `ifid_write`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  IF/ID loads a NOP.
- `idex_write`  out  1  ID/EX load enable.
- `idex_flush`  out  1  ID/EX loads all-zero control signals (bubble).
- `exmem_write`  out  1  EX/MEM and MEM/WB load enable.
- `mem_err`  out  1  sticky flag: memory watchdog expired.

## Operation
- States: RUN, LOAD_STALL, MEM_WAIT.
- Hazard term `lu` = `ex_MemRead` & (`ex_rd` != 0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- Wait term `mw` = `mem_req` & !`mem_ready`.
- Priority is fixed: `mw` over `ex_redirect` over `lu`.
  - `mw`: freeze all stages. `pc_write`=`ifid_write`=`idex_write`=`exmem_write`=0, no flushes.
  - `ex_redirect` (and !`mw`): `pc_write`=1, `ifid_flush`=1, `idex_flush`=1, other enables 1. A load-use in a wrong-path ID instruction is ignored.
  - `lu` in RUN (and neither above): `pc_write`=0, `ifid_write`=0, `idex_flush`=1, `exmem_write`=1.
  - Otherwise all enables are 1 and all flushes are 0.
- Transitions:
  - RUN→MEM_WAIT on `mw`.
  - RUN→LOAD_STALL on `lu` & !`ex_redirect` & !`mw`.
  - LOAD_STALL→RUN after exactly one cycle. In LOAD_STALL `lu` is not evaluated, which guarantees a single bubble. If `mw` is asserted in LOAD_STALL, go to MEM_WAIT.
  - MEM_WAIT→RUN when `mem_ready`=1. That cycle outputs are evaluated as in RUN (redirect and load-use are honoured).
- Watchdog counter, width clog2(MEM_TIMEOUT+1):
  - Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
  - On reaching MEM_TIMEOUT, set `mem_err`=1 and force the next state to RUN, treating the access as complete for that cycle.
  - `mem_err` is cleared only by `rst`.

## Timing
- Outputs are combinational from the current state and current inputs, so a stall takes effect in the same cycle it is detected. The state register and counters update on `clk`.
- While `rst`=1: `pc_write`=`ifid_write`=`idex_write`=`exmem_write`=0, `ifid_flush`=`idex_flush`=1, `mem_err`=0, state=RUN, watchdog=0, perf counters=0.
- Reset asserted mid-stall or mid-wait returns the state to RUN immediately (asynchronous).
- Load-use costs exactly 1 cycle. Redirect costs 2 squashed instructions, 0 stall cycles.
- A memory wait of N cycles freezes the pipeline for N cycles. `mem_ready` arriving in the same cycle as `mem_req` costs 0 cycles.
- `ex_redirect` held during MEM_WAIT is acted on in the cycle `mem_ready` rises, because EX is frozen and the input stays stable.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Adds outputs `stall_cnt`, `flush_cnt` and `memwait_cnt`, each 32-bit.
  - They count cycles with `lu` stalls, cycles with `ex_redirect` flushes, and MEM_WAIT cycles.
  - All three reset to 0 and wrap modulo 2^32.
- Not defined: the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Shared package `hazard_pkg`: state enum `hz_state_t` {RUN, LOAD_STALL, MEM_WAIT} and the register-index width constant `REG_IDX_W`=5.
- One sub-module, `hazard_perf_counter`, holding the three counters. It is instantiated only under `HAZARD_PERF_CNT_EN`.

## Test plan
- Load x5 in EX, ID reads x5 as rs1 → one cycle with `pc_write`=0 and `idex_flush`=1, then normal flow. With `ex_rd`=0 → no stall.
- Taken branch in EX while the ID instruction has a load-use on x7 → `ifid_flush`=`idex_flush`=1, `pc_write`=1, no stall cycle.
- `mem_req`=1 with `mem_ready` low for 3 cycles → all enables 0 for 3 cycles, RUN on cycle 4, `mem_err`=0.
- MEM_TIMEOUT=4, `mem_ready` held low → `mem_err` rises after 4 wait cycles, state returns to RUN, `mem_err` stays 1 until `rst`.
- `rst` pulsed during MEM_WAIT → outputs take reset values asynchronously, and RUN follows release.
- With `HAZARD_PERF_CNT_EN`: 2 load-use stalls, 1 redirect and 3 wait cycles → `stall_cnt`=2, `flush_cnt`=1, `memwait_cnt`=3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard / stall controller.
package hazard_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } hz_state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// Free-running 32-bit event counters for load-use stalls, redirect flushes and memory-wait cycles.
module hazard_perf_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_inc_i,
   input  logic        flush_inc_i,
   input  logic        wait_inc_i,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o,
   output logic [31:0] memwait_cnt_o
);

   logic [31:0] stall_q, stall_d;
   logic [31:0] flush_q, flush_d;
   logic [31:0] wait_q,  wait_d;

   assign stall_d = stall_q + {31'd0, stall_inc_i};
   assign flush_d = flush_q + {31'd0, flush_inc_i};
   assign wait_d  = wait_q  + {31'd0, wait_inc_i};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
         wait_q  <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
         wait_q  <= wait_d;
      end
   end

   assign stall_cnt_o   = stall_q;
   assign flush_cnt_o   = flush_q;
   assign memwait_cnt_o = wait_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: memory-wait freeze, taken-redirect squash and single-bubble load-use stall.
// Define HAZARD_PERF_CNT_EN to add the stall_cnt / flush_cnt / memwait_cnt counter outputs.
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_use_rs1,
   input  logic                 id_use_rs2,
   input  logic [REG_IDX_W-1:0] ex_rd,
   input  logic                 ex_MemRead,
   input  logic                 ex_redirect,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 ifid_write,
   output logic                 ifid_flush,
   output logic                 idex_write,
   output logic                 idex_flush,
   output logic                 exmem_write,
   output logic                 mem_err,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0]          stall_cnt,
   output logic [31:0]          flush_cnt,
   output logic [31:0]          memwait_cnt,
`endif
   output hz_state_t            dbg_state
);

   localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_t       state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            mem_err_q, mem_err_d;

   logic lu, mw, timeout, mw_eff, redirect_flush, lu_stall;

   assign lu = ex_MemRead && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
   assign mw = mem_req && !mem_ready;

   // On watchdog expiry the stuck access is treated as complete, so the pipeline unfreezes that cycle.
   assign timeout        = (state_q == MEM_WAIT) && mw && (wd_q == WD_W'(MEM_TIMEOUT - 1));
   assign mw_eff         = mw && !timeout;
   assign redirect_flush = !mw_eff && ex_redirect;
   assign lu_stall       = !mw_eff && !ex_redirect && lu && (state_q != LOAD_STALL);

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      if (rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_write  = 1'b0;
         idex_flush  = 1'b1;
         exmem_write = 1'b0;
      end else if (mw_eff) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
      end else if (redirect_flush) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (lu_stall) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      mem_err_d = mem_err_q || timeout;
      case (state_q)
         RUN: begin
            if (mw) begin
               state_d = MEM_WAIT;
               wd_d    = '0;
            end else if (lu_stall) begin
               state_d = LOAD_STALL;
            end
         end
         LOAD_STALL: begin
            if (mw) begin
               state_d = MEM_WAIT;
               wd_d    = '0;
            end else begin
               state_d = RUN;
            end
         end
         MEM_WAIT: begin
            if (mw) wd_d = wd_q + 1'b1;
            // A load-use bubble issued on the release cycle still gets its one-cycle lu mask.
            if (timeout)       state_d = RUN;
            else if (!mw_eff)  state_d = lu_stall ? LOAD_STALL : RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         wd_q      <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err   = mem_err_q;
   assign dbg_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_counter u_perf (
      .clk           (clk),
      .rst           (rst),
      .stall_inc_i   (lu_stall),
      .flush_inc_i   (redirect_flush),
      .wait_inc_i    (mw_eff),
      .stall_cnt_o   (stall_cnt),
      .flush_cnt_o   (flush_cnt),
      .memwait_cnt_o (memwait_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table, directed multi-cycle sequences, random vs. reference model.
module tb_hazard_stall_controller;
   import hazard_pkg::*;

   localparam int T = 4;

   // Output bundle order: {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write}
   localparam logic [5:0] O_NORM  = 6'b110101;
   localparam logic [5:0] O_STALL = 6'b000111;
   localparam logic [5:0] O_REDIR = 6'b111111;
   localparam logic [5:0] O_FRZ   = 6'b000000;
   localparam logic [5:0] O_RST   = 6'b001010;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_MemRead, ex_redirect, mem_req, mem_ready;
   logic       pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, mem_err;
   hz_state_t  dbg_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
`endif
   logic [5:0] dut_out;

   int checks   = 0;
   int failures = 0;

   // Reference model state: sticky error, frozen-run length, "lu masked this cycle", expected FSM state.
   bit          m_err;
   bit          m_supp;
   int          m_run;
   hz_state_t   m_state;
   logic [31:0] m_stall, m_flush, m_wait;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       rdr;
      logic       mq;
      logic       my;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl [11];

   always #5 clk = ~clk;

   hazard_stall_controller #(.MEM_TIMEOUT(T)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_MemRead  (ex_MemRead),
      .ex_redirect (ex_redirect),
      .mem_req     (mem_req),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write),
      .ifid_write  (ifid_write),
      .ifid_flush  (ifid_flush),
      .idex_write  (idex_write),
      .idex_flush  (idex_flush),
      .exmem_write (exmem_write),
      .mem_err     (mem_err),
`ifdef HAZARD_PERF_CNT_EN
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
      .memwait_cnt (memwait_cnt),
`endif
      .dbg_state   (dbg_state)
   );

   assign dut_out = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_err   = 1'b0;
      m_supp  = 1'b0;
      m_run   = 0;
      m_state = RUN;
      m_stall = '0;
      m_flush = '0;
      m_wait  = '0;
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic rdr, input logic mq,
                        input logic my);
      id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      ex_rd = rd; ex_MemRead = mr; ex_redirect = rdr; mem_req = mq; mem_ready = my;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Called #1 after a rising edge with inputs driven; checks this cycle, advances the model, ends #1 after the next edge.
   task automatic cycle(input string tag, input bit use_hand, input logic [5:0] hand);
      bit lu, mw, tmo, frozen, stalled;
      logic [5:0] exp;
      #2;
      if (rst) begin
         model_reset();
         exp = O_RST;
      end else begin
         lu = ex_MemRead && (ex_rd != 5'd0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
         mw      = mem_req && !mem_ready;
         tmo     = mw && (m_run == T);
         frozen  = mw && !tmo;
         stalled = !frozen && !ex_redirect && lu && !m_supp;
         if (frozen)           exp = O_FRZ;
         else if (ex_redirect) exp = O_REDIR;
         else if (stalled)     exp = O_STALL;
         else                  exp = O_NORM;
      end
      check({tag, "/out"}, 32'(dut_out), 32'(exp));
      if (use_hand) check({tag, "/hand"}, 32'(dut_out), 32'(hand));
      check({tag, "/state"}, 32'(dbg_state), 32'(m_state));
      check({tag, "/mem_err"}, 32'(mem_err), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
      check({tag, "/stall_cnt"}, stall_cnt, m_stall);
      check({tag, "/flush_cnt"}, flush_cnt, m_flush);
      check({tag, "/memwait_cnt"}, memwait_cnt, m_wait);
`endif
      if (!rst) begin
         m_err   = m_err || tmo;
         m_run   = frozen ? m_run + 1 : 0;
         m_supp  = stalled && !tmo;
         m_state = frozen ? MEM_WAIT : (m_supp ? LOAD_STALL : RUN);
         m_stall = m_stall + 32'(stalled);
         m_flush = m_flush + 32'(!frozen && ex_redirect);
         m_wait  = m_wait + 32'(frozen);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      tbl[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL};
      tbl[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[3]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[4]  = '{5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL};
      tbl[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[6]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, O_REDIR};
      tbl[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_FRZ};
      tbl[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NORM};
      tbl[9]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, O_FRZ};
      tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_REDIR};

      // Reset values while rst is held
      rst = 1'b1;
      idle();
      model_reset();
      #3;
      check("rst/out", 32'(dut_out), 32'(O_RST));
      check("rst/state", 32'(dbg_state), 32'(RUN));
      check("rst/mem_err", 32'(mem_err), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].mr, tbl[i].rdr,
               tbl[i].mq, tbl[i].my);
         cycle($sformatf("tbl%0d", i), 1'b1, tbl[i].exp);
         idle();
         cycle($sformatf("tbl%0d_idle", i), 1'b1, O_NORM);
      end

      // Load-use: exactly one bubble even with the hazard inputs held
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("lu_first", 1'b1, O_STALL);
      check("lu_state", 32'(dbg_state), 32'(LOAD_STALL));
      cycle("lu_second", 1'b1, O_NORM);
      idle();
      cycle("lu_after", 1'b1, O_NORM);

      // Three-cycle memory wait
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cycle($sformatf("mw3_%0d", k), 1'b1, O_FRZ);
      mem_ready = 1'b1;
      cycle("mw3_done", 1'b1, O_NORM);
      check("mw3_state", 32'(dbg_state), 32'(RUN));
      check("mw3_err", 32'(mem_err), 32'd0);
      idle();
      cycle("mw3_idle", 1'b1, O_NORM);

      // Watchdog expiry and stickiness of mem_err
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < T; k++) cycle($sformatf("wd_%0d", k), 1'b1, O_FRZ);
      cycle("wd_expire", 1'b1, O_NORM);
      check("wd_err", 32'(mem_err), 32'd1);
      check("wd_state", 32'(dbg_state), 32'(RUN));
      cycle("wd_rewait", 1'b1, O_FRZ);
      mem_ready = 1'b1;
      cycle("wd_release", 1'b1, O_NORM);
      idle();
      cycle("wd_sticky", 1'b1, O_NORM);
      check("wd_err_sticky", 32'(mem_err), 32'd1);

      // Asynchronous reset in the middle of a wait
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle("ar_enter", 1'b1, O_FRZ);
      #2;
      check("ar_frozen", 32'(dut_out), 32'(O_FRZ));
      #2;
      rst = 1'b1;
      #1;
      check("ar_out", 32'(dut_out), 32'(O_RST));
      check("ar_state", 32'(dbg_state), 32'(RUN));
      check("ar_err", 32'(mem_err), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle();
      cycle("ar_release", 1'b1, O_NORM);

      // Redirect held across a wait acts on the release cycle
      drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle("rw_0", 1'b1, O_FRZ);
      cycle("rw_1", 1'b1, O_FRZ);
      mem_ready = 1'b1;
      cycle("rw_go", 1'b1, O_REDIR);
      idle();
      cycle("rw_idle", 1'b1, O_NORM);

      // Event-count scenario: 2 load-use stalls, 1 redirect, 3 wait cycles
      do_reset();
      for (int k = 0; k < 2; k++) begin
         drive(5'd4, 5'd4, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
         cycle("pc_lu", 1'b1, O_STALL);
         idle();
         cycle("pc_lu_idle", 1'b1, O_NORM);
      end
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle("pc_redir", 1'b1, O_REDIR);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cycle("pc_wait", 1'b1, O_FRZ);
      mem_ready = 1'b1;
      cycle("pc_done", 1'b1, O_NORM);
`ifdef HAZARD_PERF_CNT_EN
      check("pc_stall_cnt", stall_cnt, 32'd2);
      check("pc_flush_cnt", flush_cnt, 32'd1);
      check("pc_memwait_cnt", memwait_cnt, 32'd3);
`endif

      // Random traffic against the reference model; memory requests tend to persist while waiting
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) < 2),
               (m_run > 0) ? 1'($urandom_range(0, 9) < 9) : 1'($urandom_range(0, 9) < 3),
               1'($urandom_range(0, 3) == 0));
         cycle("rand", 1'b0, O_NORM);
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
